// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle for the multi-cycle RV32I control unit.
// Master = control unit (drives selects/enables), slave = datapath/memory side.
// Pure wiring, no state.
interface multicycle_control_unit_if #(
    parameter int ALUCTRL_W = 4,
    parameter int IMMSRC_W  = 3
);
    // datapath -> control
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7_5;
    logic                 zero;
    logic                 lt;
    logic                 ltu;
    logic                 mem_ready;
    // control -> datapath
    logic                 mem_req;
    logic                 mem_write;
    logic                 adr_src;
    logic                 ir_write;
    logic                 pc_write;
    logic                 pc_clr_lsb;
    logic                 reg_write;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           result_src;
    logic [IMMSRC_W-1:0]  imm_src;
    logic [ALUCTRL_W-1:0] alu_control;
    logic                 illegal;
    logic [3:0]           state_dbg;

    modport master (
        input  op, funct3, funct7_5, zero, lt, ltu, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, pc_clr_lsb,
               reg_write, alu_src_a, alu_src_b, result_src, imm_src,
               alu_control, illegal, state_dbg
    );

    modport slave (
        output op, funct3, funct7_5, zero, lt, ltu, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, pc_clr_lsb,
               reg_write, alu_src_a, alu_src_b, result_src, imm_src,
               alu_control, illegal, state_dbg
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM (fetch/decode/execute/memory/writeback); UPPER_IMM_EN adds LUI/AUIPC.
// Latency: 3-5 states per instruction plus memory wait cycles; outputs decoded from current state.
// Backpressure: holds in FETCH/MEMREAD/MEMWRITE until mem_ready; optional MEM_TIMEOUT traps to ILLEGAL.
module multicycle_control_unit #(
    parameter int ALUCTRL_W   = 4,
    parameter int IMMSRC_W    = 3,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_unit_if.master cu
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEMADR   = 4'd2,  S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5,  S_EXEC_R   = 4'd6,  S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,  S_BRANCH   = 4'd9,  S_JAL      = 4'd10, S_JALR_ADR = 4'd11,
        S_JALR_PC  = 4'd12, S_EXEC_U   = 4'd13, S_ILLEGAL  = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011, OP_R    = 7'b0110011,
                           OP_I     = 7'b0010011, OP_BR    = 7'b1100011, OP_JAL  = 7'b1101111,
                           OP_JALR  = 7'b1100111, OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                           ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_PASSB = 4'd10;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd4;

    localparam int CNT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int CNT_LIM = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q;
    logic             taken, br_ok, mem_wait, timeout;
    logic [3:0]       alu_d;
    logic [2:0]       imm_d;
    logic             mem_req_d, mem_write_d, ir_write_d, pc_write_d, reg_write_d;

    // funct7_5 picks SUB for 000 and SRA for 101; caller masks it for I-type.
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_dec = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

    // Branch condition from ALU flags; 010/011 are not valid branch encodings.
    always_comb begin
        taken = 1'b0;
        br_ok = 1'b1;
        case (cu.funct3)
            3'b000:  taken = cu.zero;
            3'b001:  taken = ~cu.zero;
            3'b100:  taken = cu.lt;
            3'b101:  taken = ~cu.lt;
            3'b110:  taken = cu.ltu;
            3'b111:  taken = ~cu.ltu;
            default: br_ok = 1'b0;
        endcase
    end

    // Moore output decode from state and IR fields.
    always_comb begin
        mem_req_d     = 1'b0;
        mem_write_d   = 1'b0;
        ir_write_d    = 1'b0;
        pc_write_d    = 1'b0;
        reg_write_d   = 1'b0;
        cu.adr_src    = 1'b0;
        cu.pc_clr_lsb = 1'b0;
        cu.alu_src_a  = 2'b00;
        cu.alu_src_b  = 2'b00;
        cu.result_src = 2'b00;
        imm_d         = IMM_I;
        alu_d         = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_d     = 1'b1;
                cu.alu_src_b  = 2'b10;
                cu.result_src = 2'b10;
                if (cu.mem_ready) begin
                    ir_write_d = 1'b1;
                    pc_write_d = 1'b1;
                end
            end
            S_DECODE: begin
                cu.alu_src_a = 2'b01;
                cu.alu_src_b = 2'b01;
                imm_d        = IMM_B;
            end
            S_MEMADR: begin
                cu.alu_src_a = 2'b10;
                cu.alu_src_b = 2'b01;
                imm_d        = cu.op[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                mem_req_d  = 1'b1;
                cu.adr_src = 1'b1;
            end
            S_MEMWB: begin
                cu.result_src = 2'b01;
                reg_write_d   = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_d   = 1'b1;
                mem_write_d = 1'b1;
                cu.adr_src  = 1'b1;
            end
            S_EXEC_R: begin
                cu.alu_src_a = 2'b10;
                alu_d        = alu_dec(cu.funct3, cu.funct7_5);
            end
            S_EXEC_I: begin
                cu.alu_src_a = 2'b10;
                cu.alu_src_b = 2'b01;
                alu_d        = alu_dec(cu.funct3, cu.funct7_5 & (cu.funct3 == 3'b101));
            end
            S_ALUWB: begin
                // ALU keeps computing OldPC+4, the link value of JAL/JALR.
                reg_write_d  = 1'b1;
                cu.alu_src_a = 2'b01;
                cu.alu_src_b = 2'b10;
            end
            S_BRANCH: begin
                cu.alu_src_a = 2'b10;
                alu_d        = ALU_SUB;
                pc_write_d   = taken & br_ok;
            end
            S_JAL: begin
                pc_write_d   = 1'b1;
                cu.alu_src_a = 2'b01;
                cu.alu_src_b = 2'b10;
            end
            S_JALR_ADR: begin
                cu.alu_src_a = 2'b10;
                cu.alu_src_b = 2'b01;
            end
            S_JALR_PC: begin
                pc_write_d    = 1'b1;
                cu.pc_clr_lsb = 1'b1;
                cu.alu_src_a  = 2'b01;
                cu.alu_src_b  = 2'b10;
            end
`ifdef UPPER_IMM_EN
            S_EXEC_U: begin
                cu.alu_src_b = 2'b01;
                imm_d        = IMM_U;
                if (cu.op == OP_LUI) begin
                    alu_d = ALU_PASSB;
                end else begin
                    cu.alu_src_a = 2'b01;
                end
            end
`endif
            default: ;
        endcase
    end

    assign mem_wait = mem_req_d & ~cu.mem_ready;
    assign timeout  = (MEM_TIMEOUT > 0) && mem_wait && (cnt_q == CNT_W'(CNT_LIM));

    // Next-state and memory-wait counter; a timeout overrides any hold.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (cu.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (cu.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR_ADR;
`ifdef UPPER_IMM_EN
                    OP_LUI, OP_AUIPC:  state_d = S_EXEC_U;
`endif
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = cu.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (cu.mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (cu.mem_ready) state_d = S_FETCH;
            S_MEMWB, S_ALUWB: state_d = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_EXEC_U, S_JAL, S_JALR_PC: state_d = S_ALUWB;
            S_BRANCH:   state_d = br_ok ? S_FETCH : S_ILLEGAL;
            S_JALR_ADR: state_d = S_JALR_PC;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
        if (timeout) state_d = S_ILLEGAL;

        if ((state_d != state_q) || cu.mem_ready || (MEM_TIMEOUT == 0)) cnt_d = '0;
        else if (mem_wait)                                                cnt_d = cnt_q + 1'b1;
        else                                                              cnt_d = cnt_q;
    end

    // State, counter and sticky trap flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_q | (state_d == S_ILLEGAL);
        end
    end

    // Enables are suppressed while reset is held so an aborted instruction writes nothing.
    assign cu.mem_req     = mem_req_d   & rst_n;
    assign cu.mem_write   = mem_write_d & rst_n;
    assign cu.ir_write    = ir_write_d  & rst_n;
    assign cu.pc_write    = pc_write_d  & rst_n;
    assign cu.reg_write   = reg_write_d & rst_n;
    assign cu.imm_src     = IMMSRC_W'(imm_d);
    assign cu.alu_control = ALUCTRL_W'(alu_d);
    assign cu.illegal     = illegal_q;
    assign cu.state_dbg   = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f75, zero, lt, ltu, mem_ready;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ALUCTRL_W(4), .IMMSRC_W(3)) bus4 ();
    multicycle_control_unit_if #(.ALUCTRL_W(4), .IMMSRC_W(3)) bus0 ();

    assign bus4.op = op;  assign bus4.funct3 = f3;  assign bus4.funct7_5 = f75;
    assign bus4.zero = zero;  assign bus4.lt = lt;  assign bus4.ltu = ltu;
    assign bus4.mem_ready = mem_ready;
    assign bus0.op = op;  assign bus0.funct3 = f3;  assign bus0.funct7_5 = f75;
    assign bus0.zero = zero;  assign bus0.lt = lt;  assign bus0.ltu = ltu;
    assign bus0.mem_ready = mem_ready;

    multicycle_control_unit #(.ALUCTRL_W(4), .IMMSRC_W(3), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .cu(bus4));
    multicycle_control_unit #(.ALUCTRL_W(4), .IMMSRC_W(3), .MEM_TIMEOUT(0)) dut_nt (
        .clk(clk), .rst_n(rst_n), .cu(bus0));

    localparam int F_ST = 0, F_MREQ = 1, F_MWR = 2, F_ADR = 3, F_IRW = 4, F_PCW = 5,
                   F_CLR = 6, F_REGW = 7, F_SA = 8, F_SB = 9, F_RES = 10, F_IMM = 11,
                   F_ALU = 12, F_ILL = 13, F_ST0 = 14;

    typedef struct {
        string      tag;
        int         f;
        logic [7:0] v;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [7:0] obs(int f);
        case (f)
            F_ST:    return 8'(bus4.state_dbg);
            F_MREQ:  return 8'(bus4.mem_req);
            F_MWR:   return 8'(bus4.mem_write);
            F_ADR:   return 8'(bus4.adr_src);
            F_IRW:   return 8'(bus4.ir_write);
            F_PCW:   return 8'(bus4.pc_write);
            F_CLR:   return 8'(bus4.pc_clr_lsb);
            F_REGW:  return 8'(bus4.reg_write);
            F_SA:    return 8'(bus4.alu_src_a);
            F_SB:    return 8'(bus4.alu_src_b);
            F_RES:   return 8'(bus4.result_src);
            F_IMM:   return 8'(bus4.imm_src);
            F_ALU:   return 8'(bus4.alu_control);
            F_ILL:   return 8'(bus4.illegal);
            default: return 8'(bus0.state_dbg);
        endcase
    endfunction

    task automatic ex(input string tag, input int f, input int v);
        exp_t e;
        e.tag = tag;
        e.f   = f;
        e.v   = 8'(v);
        sb.push_back(e);
    endtask

    // Compare all expectations queued for this cycle mid-cycle, then advance.
    task automatic cyc();
        exp_t       e;
        logic [7:0] o;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.f);
            tests++;
            assert (o === e.v) else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.v);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f, input logic s);
        op = o; f3 = f; f75 = s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ex("rst_mem_req", F_MREQ, 0); ex("rst_mem_write", F_MWR, 0);
        ex("rst_ir_write", F_IRW, 0); ex("rst_pc_write", F_PCW, 0);
        ex("rst_reg_write", F_REGW, 0);
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic fetch_decode();
        mem_ready = 1'b1;
        ex("fetch_state", F_ST, 0); ex("fetch_ir_write", F_IRW, 1);
        ex("fetch_pc_write", F_PCW, 1); ex("fetch_src_b", F_SB, 2); ex("fetch_res", F_RES, 2);
        cyc();
        ex("decode_state", F_ST, 1); ex("decode_imm", F_IMM, 2);
        ex("decode_src_a", F_SA, 1); ex("decode_src_b", F_SB, 1);
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);

        // Reset: enables forced low, second reset cycle already sits in FETCH.
        do_reset();
        rst_n = 1'b0;
        ex("rst_state", F_ST, 0); ex("rst_illegal", F_ILL, 0); ex("rst_fetch_pc_write", F_PCW, 0);
        cyc();
        rst_n = 1'b1;

        // ADD then SUB: 4-cycle R-type.
        for (int s = 0; s < 2; s++) begin
            set_instr(7'b0110011, 3'b000, s[0]);
            fetch_decode();
            ex("execr_state", F_ST, 6); ex("execr_alu", F_ALU, s); ex("execr_src_a", F_SA, 2);
            ex("execr_regw", F_REGW, 0);
            cyc();
            ex("aluwb_state", F_ST, 8); ex("aluwb_regw", F_REGW, 1); ex("aluwb_res", F_RES, 0);
            cyc();
        end

        // ADDI with bit30 set stays ADD; SRAI honours it.
        set_instr(7'b0010011, 3'b000, 1'b1);
        fetch_decode();
        ex("addi_state", F_ST, 7); ex("addi_alu", F_ALU, 0); ex("addi_src_b", F_SB, 1);
        cyc();
        cyc();
        set_instr(7'b0010011, 3'b101, 1'b1);
        fetch_decode();
        ex("srai_alu", F_ALU, 9);
        cyc();
        cyc();

        // LW with two wait cycles in FETCH and in MEMREAD: 9 cycles.
        set_instr(7'b0000011, 3'b010, 1'b0);
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ex("lw_fetch_wait_state", F_ST, 0); ex("lw_fetch_wait_ir", F_IRW, 0);
            ex("lw_fetch_wait_req", F_MREQ, 1);
            cyc();
        end
        fetch_decode();
        ex("lw_memadr_state", F_ST, 2); ex("lw_memadr_imm", F_IMM, 0); ex("lw_memadr_src_a", F_SA, 2);
        cyc();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_ready = 1'b1;
            ex("lw_memread_state", F_ST, 3); ex("lw_memread_adr", F_ADR, 1);
            ex("lw_memread_req", F_MREQ, 1);
            cyc();
        end
        ex("lw_memwb_state", F_ST, 4); ex("lw_memwb_res", F_RES, 1); ex("lw_memwb_regw", F_REGW, 1);
        cyc();

        // Branch sweep: {funct3, zero, lt, ltu, expected pc_write}.
        begin
            logic [2:0] bf [4] = '{3'b001, 3'b000, 3'b100, 3'b111};
            logic [2:0] fl [4] = '{3'b000, 3'b000, 3'b010, 3'b001};
            logic       tk [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
            for (int i = 0; i < 4; i++) begin
                set_instr(7'b1100011, bf[i], 1'b0);
                fetch_decode();
                {zero, lt, ltu} = fl[i];
                ex("br_state", F_ST, 9); ex("br_alu", F_ALU, 1); ex("br_pc_write", F_PCW, tk[i]);
                cyc();
                {zero, lt, ltu} = 3'b000;
            end
        end

        // JAL then ALUWB.
        set_instr(7'b1101111, 3'b000, 1'b0);
        fetch_decode();
        ex("jal_state", F_ST, 10); ex("jal_pc_write", F_PCW, 1); ex("jal_src_a", F_SA, 1);
        cyc();
        ex("jal_aluwb_state", F_ST, 8);
        cyc();

        // JALR: address, PC update with LSB clear, link writeback.
        set_instr(7'b1100111, 3'b000, 1'b0);
        fetch_decode();
        ex("jalr_adr_state", F_ST, 11); ex("jalr_adr_src_a", F_SA, 2); ex("jalr_adr_pcw", F_PCW, 0);
        cyc();
        ex("jalr_pc_state", F_ST, 12); ex("jalr_pc_write", F_PCW, 1); ex("jalr_clr_lsb", F_CLR, 1);
        cyc();
        ex("jalr_wb_regw", F_REGW, 1); ex("jalr_wb_src_a", F_SA, 1); ex("jalr_wb_src_b", F_SB, 2);
        ex("jalr_wb_clr", F_CLR, 0);
        cyc();

        // SW: reset asserted in MEMWRITE with mem_ready high aborts the store.
        set_instr(7'b0100011, 3'b010, 1'b0);
        fetch_decode();
        ex("sw_memadr_imm", F_IMM, 1);
        cyc();
        mem_ready = 1'b0;
        ex("sw_memwrite_state", F_ST, 5); ex("sw_mem_write", F_MWR, 1); ex("sw_adr", F_ADR, 1);
        cyc();
        mem_ready = 1'b1;
        rst_n = 1'b0;
        ex("sw_rst_mem_write", F_MWR, 0); ex("sw_rst_mem_req", F_MREQ, 0);
        cyc();
        rst_n = 1'b1; mem_ready = 1'b0;
        ex("sw_after_rst_state", F_ST, 0);
        cyc();

        // mem_ready arriving on the last allowed wait cycle wins over the timeout.
        set_instr(7'b0110011, 3'b000, 1'b0);
        mem_ready = 1'b0;
        cyc(); cyc();
        mem_ready = 1'b1;
        ex("limit_ready_ir", F_IRW, 1);
        cyc();
        ex("limit_ready_decode", F_ST, 1); ex("limit_ready_ill", F_ILL, 0);
        cyc();
        cyc(); cyc();

        // Timeout: four waiting cycles in FETCH then ILLEGAL; the no-timeout instance keeps waiting.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ex("to_wait_state", F_ST, 0); ex("to_wait_req", F_MREQ, 1);
            cyc();
        end
        ex("to_state", F_ST, 14); ex("to_illegal", F_ILL, 1); ex("to_mem_req", F_MREQ, 0);
        ex("nt_still_fetch", F_ST0, 0);
        cyc();
        ex("to_sticky", F_ILL, 1); ex("to_stays", F_ST, 14);
        cyc();
        do_reset();
        ex("to_rst_state", F_ST, 0); ex("to_rst_illegal", F_ILL, 0);
        cyc();

        // Invalid branch funct3 traps without pc_write.
        set_instr(7'b1100011, 3'b010, 1'b0);
        fetch_decode();
        zero = 1'b1;
        ex("br010_pc_write", F_PCW, 0);
        cyc();
        ex("br010_state", F_ST, 14); ex("br010_illegal", F_ILL, 1);
        cyc();
        zero = 1'b0;
        do_reset();

        // LUI is not decoded in the default build.
        set_instr(7'b0110111, 3'b000, 1'b0);
        fetch_decode();
        ex("lui_illegal_state", F_ST, 14); ex("lui_illegal_flag", F_ILL, 1); ex("lui_regw", F_REGW, 0);
        cyc();
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
